// File: rtl/mem_bus_ctrl_if.sv
// Requester-side handshake bundle for mem_bus_ctrl: one CPU port and one DMA port.
// master = requester side, slave = controller side.
interface mem_bus_ctrl_if;
  logic        cpu_req;
  logic        cpu_we;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic        cpu_done;

  logic        dma_req;
  logic        dma_we;
  logic [15:0] dma_addr;
  logic [7:0]  dma_wdata;
  logic [7:0]  dma_rdata;
  logic        dma_done;

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_done,
    output dma_req, dma_we, dma_addr, dma_wdata,
    input  dma_rdata, dma_done
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_done,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    output dma_rdata, dma_done
  );
endinterface

// File: rtl/mem_bus_ctrl.sv
// Two-requester (CPU/DMA) external memory bus controller with ready/timeout handling.
//   state  | meaning
//   IDLE   | sample requests, arbitrate, latch winner
//   ADDR   | address out, strobes low (1 cycle)
//   STROBE | rd/wr strobe until bus_ready or timeout
//   HOLD   | strobes low, done/rdata/error to winner (1 cycle)
module mem_bus_ctrl #(
  parameter int TIMEOUT = 255
) (
  input  logic          clock,
  input  logic          reset,
  mem_bus_ctrl_if.slave req,
  output logic [15:0]   addressBus,
  inout  wire  [7:0]    dataBus,
  output logic          bus_rd,
  output logic          bus_wr,
  input  logic          bus_ready,
  output logic          bus_error,
  output logic          grant_dma
);

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ADDR, STROBE, HOLD} state_t;

  state_t     state, state_nxt;
  logic       lat_we;
  logic [7:0] lat_wdata;
  logic [7:0] wait_cnt;
  logic [7:0] cnt_inc;
  logic [7:0] rd_val;
  logic       err_flag;
  logic       last_dma;
  logic       start;
  logic       pick_dma;
  logic       timeout_hit;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    start       = 1'b0;
    pick_dma    = 1'b0;
    timeout_hit = 1'b0;
    cnt_inc     = wait_cnt + 8'd1;
    case (state)
      IDLE: begin
        if (req.cpu_req || req.dma_req) begin
          start     = 1'b1;
          // DMA has priority except right after a DMA cycle, so neither side starves
          pick_dma  = req.dma_req && !(req.cpu_req && last_dma);
          state_nxt = ADDR;
        end
      end
      ADDR:   state_nxt = STROBE;
      STROBE: begin
        if (bus_ready) begin
          state_nxt = HOLD;
        end else if (cnt_inc == TIMEOUT_CNT) begin
          state_nxt   = HOLD;
          timeout_hit = 1'b1;
        end
      end
      HOLD:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign bus_rd        = (state == STROBE) && !lat_we;
  assign bus_wr        = (state == STROBE) && lat_we;
  assign req.cpu_done  = (state == HOLD) && !grant_dma;
  assign req.dma_done  = (state == HOLD) && grant_dma;
  assign bus_error     = (state == HOLD) && err_flag;
  assign dataBus       = (lat_we && (state != IDLE)) ? lat_wdata : 8'hzz;
  assign rd_val        = timeout_hit ? 8'hFF : dataBus;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      lat_we        <= 1'b0;
      lat_wdata     <= 8'h00;
      addressBus    <= 16'h0000;
      grant_dma     <= 1'b0;
      wait_cnt      <= 8'h00;
      err_flag      <= 1'b0;
      last_dma      <= 1'b0;
      req.cpu_rdata <= 8'h00;
      req.dma_rdata <= 8'h00;
    end else begin
      if (start) begin
        lat_we     <= pick_dma ? req.dma_we    : req.cpu_we;
        addressBus <= pick_dma ? req.dma_addr  : req.cpu_addr;
        lat_wdata  <= pick_dma ? req.dma_wdata : req.cpu_wdata;
        grant_dma  <= pick_dma;
        wait_cnt   <= 8'h00;
        err_flag   <= 1'b0;
      end
      if (state == STROBE) begin
        wait_cnt <= cnt_inc;
        if (state_nxt == HOLD) begin
          err_flag <= timeout_hit;
          if (!lat_we) begin
            if (grant_dma) req.dma_rdata <= rd_val;
            else           req.cpu_rdata <= rd_val;
          end
        end
      end
      if (state == HOLD) begin
        last_dma  <= grant_dma;
        grant_dma <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Directed bench for mem_bus_ctrl: main instance (TIMEOUT=5) plus a TIMEOUT=3 instance
// for the timeout path; completions are checked against a queue of expected results.
module tb_mem_bus_ctrl;

  logic clock;
  logic reset;

  mem_bus_ctrl_if ifa ();
  mem_bus_ctrl_if ifb ();

  wire  [7:0]  dataBus_a;
  wire  [7:0]  dataBus_b;
  logic [15:0] addr_a, addr_b;
  logic        rd_a, wr_a, rdy_a, err_a, gnt_a;
  logic        rd_b, wr_b, rdy_b, err_b, gnt_b;

  logic        tb_oe;
  logic [7:0]  tb_d;
  assign dataBus_a = tb_oe ? tb_d : 8'hzz;
  assign dataBus_b = 8'h5A;

  mem_bus_ctrl #(.TIMEOUT(5)) u_dut (
    .clock(clock), .reset(reset), .req(ifa.slave),
    .addressBus(addr_a), .dataBus(dataBus_a),
    .bus_rd(rd_a), .bus_wr(wr_a), .bus_ready(rdy_a),
    .bus_error(err_a), .grant_dma(gnt_a)
  );

  mem_bus_ctrl #(.TIMEOUT(3)) u_dut_to (
    .clock(clock), .reset(reset), .req(ifb.slave),
    .addressBus(addr_b), .dataBus(dataBus_b),
    .bus_rd(rd_b), .bus_wr(wr_b), .bus_ready(rdy_b),
    .bus_error(err_b), .grant_dma(gnt_b)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {
    logic       is_dma;
    logic [7:0] rdata;
    logic       err;
  } exp_t;

  exp_t sb_q[$];
  exp_t sb_e;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_done(input logic d, input logic [7:0] r, input logic e);
    sb_q.push_back({d, r, e});
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Scoreboard: every completion pulse must match the next queued expectation
  always @(negedge clock) begin
    if (ifa.cpu_done === 1'b1 || ifa.dma_done === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_done", 32'({ifa.cpu_done, ifa.dma_done}), 32'd0);
      end else begin
        sb_e = sb_q.pop_front();
        chk("sb_who", 32'({ifa.dma_done, ifa.cpu_done}), sb_e.is_dma ? 32'd2 : 32'd1);
        chk("sb_rdata", 32'(sb_e.is_dma ? ifa.dma_rdata : ifa.cpu_rdata), 32'(sb_e.rdata));
        chk("sb_error", 32'(err_a), 32'(sb_e.err));
      end
    end
  end

  logic       dual_g;
  int         wr_cycles;
  int         strobe_cnt;
  logic       done_seen;

  initial begin
    reset = 1'b0;
    tb_oe = 1'b1;
    tb_d  = 8'h3C;
    rdy_a = 1'b0;
    rdy_b = 1'b0;
    ifa.cpu_req = 1'b0; ifa.cpu_we = 1'b0; ifa.cpu_addr = 16'h0; ifa.cpu_wdata = 8'h0;
    ifa.dma_req = 1'b0; ifa.dma_we = 1'b0; ifa.dma_addr = 16'h0; ifa.dma_wdata = 8'h0;
    ifb.cpu_req = 1'b0; ifb.cpu_we = 1'b0; ifb.cpu_addr = 16'h0; ifb.cpu_wdata = 8'h0;
    ifb.dma_req = 1'b0; ifb.dma_we = 1'b0; ifb.dma_addr = 16'h0; ifb.dma_wdata = 8'h0;

    #3;
    chk("rst_addr", 32'(addr_a), 32'h0);
    chk("rst_ctrl", 32'({rd_a, wr_a, ifa.cpu_done, ifa.dma_done, err_a, gnt_a}), 32'h0);
    chk("rst_rdata", 32'({ifa.cpu_rdata, ifa.dma_rdata}), 32'h0);
    chk("rst_data_z", 32'(dataBus_a), 32'h3C);
    tick();
    tick();
    reset = 1'b1;

    // CPU read; bus_ready already high in IDLE/ADDR must not shorten STROBE
    rdy_a = 1'b1;
    tb_d  = 8'h5A;
    ifa.cpu_we = 1'b0; ifa.cpu_addr = 16'h1234; ifa.cpu_req = 1'b1;
    expect_done(1'b0, 8'h5A, 1'b0);
    tick();
    chk("t1_addr_phase", 32'({addr_a, rd_a, wr_a, ifa.cpu_done}), 32'({16'h1234, 3'b000}));
    tick();
    chk("t1_strobe", 32'({rd_a, wr_a, ifa.cpu_done}), 32'b100);
    tick();
    chk("t1_done", 32'({ifa.cpu_done, ifa.dma_done, err_a, rd_a}), 32'b1000);
    chk("t1_rdata", 32'(ifa.cpu_rdata), 32'h5A);
    ifa.cpu_req = 1'b0;
    rdy_a = 1'b0;
    tick();
    chk("t1_idle", 32'({ifa.cpu_done, gnt_a}), 32'h0);
    chk("t1_rdata_hold", 32'(ifa.cpu_rdata), 32'h5A);
    chk("t1_addr_hold", 32'(addr_a), 32'h1234);

    // Sustained dual requests alternate DMA, CPU, DMA, CPU
    rdy_a = 1'b1;
    ifa.cpu_we = 1'b0; ifa.cpu_addr = 16'h2222; ifa.cpu_req = 1'b1;
    ifa.dma_we = 1'b0; ifa.dma_addr = 16'h4444; ifa.dma_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      dual_g = (k % 2 == 0);
      tb_d   = (dual_g ? 8'hA0 : 8'h50) + 8'(k);
      expect_done(dual_g, tb_d, 1'b0);
      tick();
      chk("dual_grant", 32'(gnt_a), 32'(dual_g));
      chk("dual_addr", 32'(addr_a), dual_g ? 32'h4444 : 32'h2222);
      tick();
      tick();
      chk("dual_done", 32'({ifa.dma_done, ifa.cpu_done}), dual_g ? 32'd2 : 32'd1);
      if (k == 3) begin
        ifa.cpu_req = 1'b0;
        ifa.dma_req = 1'b0;
      end
      tick();
    end
    rdy_a = 1'b0;

    // Reset in STROBE of a write abandons the cycle immediately
    tb_oe = 1'b0;
    ifa.cpu_we = 1'b1; ifa.cpu_addr = 16'h00F0; ifa.cpu_wdata = 8'h96; ifa.cpu_req = 1'b1;
    tick();
    tick();
    chk("rst_strobe_wr", 32'({wr_a, dataBus_a}), 32'({1'b1, 8'h96}));
    #2;
    reset = 1'b0;
    #1;
    chk("rst_async_ctrl", 32'({rd_a, wr_a, ifa.cpu_done, err_a, gnt_a}), 32'h0);
    chk("rst_async_addr", 32'(addr_a), 32'h0);
    chk("rst_async_rdata", 32'({ifa.cpu_rdata, ifa.dma_rdata}), 32'h0);
    tb_oe = 1'b1;
    tb_d  = 8'h3C;
    #1;
    chk("rst_async_z", 32'(dataBus_a), 32'h3C);
    tick();
    chk("rst_held", 32'({ifa.cpu_done, wr_a, rd_a}), 32'h0);
    ifa.cpu_we = 1'b0;
    rdy_a = 1'b1;
    reset = 1'b1;
    expect_done(1'b0, 8'h3C, 1'b0);
    tick();
    chk("rst_fresh_addr", 32'({addr_a, rd_a, wr_a}), 32'({16'h00F0, 2'b00}));
    tick();
    chk("rst_fresh_strobe", 32'({rd_a, ifa.cpu_done}), 32'b10);
    tick();
    chk("rst_fresh_done", 32'({ifa.cpu_done, ifa.cpu_rdata}), 32'({1'b1, 8'h3C}));
    ifa.cpu_req = 1'b0;
    rdy_a = 1'b0;
    tick();

    // DMA write, bus_ready held off 4 STROBE cycles; completes on the TIMEOUT boundary
    tb_oe = 1'b0;
    ifa.dma_we = 1'b1; ifa.dma_addr = 16'h8000; ifa.dma_wdata = 8'hC3; ifa.dma_req = 1'b1;
    expect_done(1'b1, 8'h00, 1'b0);
    tick();
    chk("t2_addr", 32'({gnt_a, addr_a, wr_a}), 32'({1'b1, 16'h8000, 1'b0}));
    chk("t2_data_addr", 32'(dataBus_a), 32'hC3);
    wr_cycles = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (wr_a === 1'b1) wr_cycles++;
      chk("t2_data_strobe", 32'(dataBus_a), 32'hC3);
      if (i == 4) rdy_a = 1'b1;
    end
    tick();
    chk("t2_done", 32'({ifa.dma_done, ifa.cpu_done, err_a, wr_a}), 32'b1000);
    chk("t2_data_hold", 32'(dataBus_a), 32'hC3);
    chk("t2_wr_cycles", 32'(wr_cycles), 32'd5);
    ifa.dma_req = 1'b0;
    rdy_a = 1'b0;
    tick();
    tb_oe = 1'b1;
    tb_d  = 8'h3C;
    #1;
    chk("t2_data_released", 32'(dataBus_a), 32'h3C);
    chk("t2_idle", 32'({ifa.dma_done, gnt_a}), 32'h0);

    // Request dropped mid-cycle still completes, and no new cycle follows
    tb_d  = 8'hE1;
    rdy_a = 1'b1;
    ifa.dma_we = 1'b0; ifa.dma_addr = 16'h0101; ifa.dma_req = 1'b1;
    expect_done(1'b1, 8'hE1, 1'b0);
    tick();
    ifa.dma_req = 1'b0;
    tick();
    tick();
    chk("drop_done", 32'({ifa.dma_done, ifa.dma_rdata}), 32'({1'b1, 8'hE1}));
    tick();
    chk("drop_idle", 32'({ifa.dma_done, gnt_a, rd_a}), 32'h0);
    chk("drop_rdata_hold", 32'(ifa.dma_rdata), 32'hE1);
    rdy_a = 1'b0;

    // Timeout instance: bus_ready never rises
    ifb.cpu_we = 1'b0; ifb.cpu_addr = 16'h0042; ifb.cpu_req = 1'b1;
    tick();
    chk("to_addr", 32'({addr_b, rd_b}), 32'({16'h0042, 1'b0}));
    strobe_cnt = 0;
    done_seen  = 1'b0;
    for (int i = 0; i < 10 && !done_seen; i++) begin
      tick();
      if (ifb.cpu_done === 1'b1) done_seen = 1'b1;
      else if (rd_b === 1'b1) strobe_cnt++;
    end
    chk("to_done_seen", 32'(done_seen), 32'd1);
    chk("to_strobes", 32'(strobe_cnt), 32'd3);
    chk("to_err_rdata", 32'({ifb.cpu_done, err_b, ifb.cpu_rdata}), 32'({2'b11, 8'hFF}));
    ifb.cpu_req = 1'b0;
    tick();
    chk("to_err_pulse", 32'({err_b, ifb.cpu_done}), 32'h0);
    chk("to_rdata_hold", 32'(ifb.cpu_rdata), 32'hFF);

    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
